o_buffer: RTL and testbench

Output buffer for the systolic array. It captures one row of ARRAY_M column results per cycle into ARRAY_M independent single-port-write RAM banks, one bank per array column. It exposes a random-access read port that selects one bank and one address. It sits between the array's output stage and the downstream read-out/DMA logic.

---
 rtl/o_buffer_if.sv | 57 +++++
 rtl/o_buffer.sv | 100 ++++++++++
 tb/tb_o_buffer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/o_buffer_if.sv
// ----------------------------------------------------------------------------
// o_buffer_if
// Bundles the write (row capture) and read (random access) signals of the
// systolic-array output buffer.
//
// Signals:
//   num_cols   number of active columns for the current row (clamped to ARRAY_M)
//   ag_o_on    write enable / address-generator run
//   data_in    one output row, lane i = data_in[OUT_WIDTH*i +: OUT_WIDTH]
//   base_addr  first write address of the current burst
//   ram_idx    bank select for reads
//   read_addr  read address within the selected bank
//   data_read  registered read data (one cycle after ram_idx/read_addr)
//
// Signalling: there is no valid/ready pair. A row is consumed on every rising
// edge where ag_o_on is high, so the producer must present a valid, deskewed
// row on every such cycle. Reads are issued every cycle and always complete.
//
// Modports:
//   master  producer/consumer side (array output stage plus read-out logic)
//   slave   the buffer itself
// ----------------------------------------------------------------------------
interface o_buffer_if #(
    parameter int RAM_SIZE   = 256,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int ARRAY_M    = 8,
    parameter int OUT_WIDTH  = 32,
    parameter int DATA_WIDTH = OUT_WIDTH
) ();
    logic [$clog2(ARRAY_M):0]       num_cols;
    logic                           ag_o_on;
    logic [ARRAY_M*OUT_WIDTH-1:0]   data_in;
    logic [ADDR_WIDTH-1:0]          base_addr;
    logic [$clog2(ARRAY_M)-1:0]     ram_idx;
    logic [ADDR_WIDTH-1:0]          read_addr;
    logic [DATA_WIDTH-1:0]          data_read;

    modport master (
        output num_cols,
        output ag_o_on,
        output data_in,
        output base_addr,
        output ram_idx,
        output read_addr,
        input  data_read
    );

    modport slave (
        input  num_cols,
        input  ag_o_on,
        input  data_in,
        input  base_addr,
        input  ram_idx,
        input  read_addr,
        output data_read
    );
endinterface

// File: rtl/o_buffer.sv
// ----------------------------------------------------------------------------
// o_buffer
// Output buffer for the systolic array. Each write cycle captures one row of
// ARRAY_M column results into ARRAY_M banks (one bank per column) at address
// (base_addr + wr_cnt) mod RAM_SIZE. A random-access read port returns
// bank[ram_idx][read_addr] one cycle later.
//
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous, active-high; clears read data and the write counter,
//          suppresses writes, leaves bank contents untouched
//   bus    o_buffer_if.slave (write row, burst base, read select, read data)
//
// There is no state machine: the only control state is the burst row counter.
// ----------------------------------------------------------------------------
module o_buffer #(
    parameter int RAM_SIZE   = 256,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int ARRAY_M    = 8,
    parameter int OUT_WIDTH  = 32,
    parameter int DATA_WIDTH = OUT_WIDTH
) (
    input  logic       clk,
    input  logic       reset,
    o_buffer_if.slave  bus
);
    localparam int NC_W  = $clog2(ARRAY_M) + 1;
    localparam int IDX_W = $clog2(ARRAY_M);

    localparam logic [ADDR_WIDTH:0]   LP_SIZE = (ADDR_WIDTH+1)'(RAM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(RAM_SIZE - 1);
    localparam logic [IDX_W:0]        LP_BANKS = (IDX_W+1)'(ARRAY_M);

    // Bank storage; not reset.
    logic [DATA_WIDTH-1:0] r_mem [ARRAY_M][RAM_SIZE];

    logic [ADDR_WIDTH-1:0] r_wr_cnt;
    logic [DATA_WIDTH-1:0] r_data_read;

    logic [ADDR_WIDTH:0]   w_sum;
    logic [ADDR_WIDTH:0]   w_sum_wrap;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [ADDR_WIDTH-1:0] w_wr_cnt_next;
    logic [ARRAY_M-1:0]    w_we;
    logic                  w_idx_ok;

    // Write address with an explicit modulo so non-power-of-two RAM_SIZE
    // also wraps correctly.
    always_comb begin
        w_sum      = {1'b0, bus.base_addr} + {1'b0, r_wr_cnt};
        w_sum_wrap = (w_sum >= LP_SIZE) ? (w_sum - LP_SIZE) : w_sum;
        w_wr_addr  = w_sum_wrap[ADDR_WIDTH-1:0];
    end

    assign w_wr_cnt_next = (r_wr_cnt == LP_LAST) ? '0 : r_wr_cnt + 1'b1;

    // Bank i is written only when it lies below num_cols. Since i < ARRAY_M,
    // num_cols above ARRAY_M naturally enables every bank.
    always_comb begin
        w_we = '0;
        for (int i = 0; i < ARRAY_M; i++) begin
            w_we[i] = bus.ag_o_on && (NC_W'(i) < bus.num_cols);
        end
    end

    // Out-of-range bank selects read as zero.
    assign w_idx_ok = ({1'b0, bus.ram_idx} < LP_BANKS);

    // Read and write share one process: the read samples the pre-edge
    // contents, which gives read-first behaviour on a same-address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_cnt    <= '0;
            r_data_read <= '0;
        end else begin
            if (w_idx_ok) begin
                r_data_read <= r_mem[bus.ram_idx][bus.read_addr];
            end else begin
                r_data_read <= '0;
            end

            for (int i = 0; i < ARRAY_M; i++) begin
                if (w_we[i]) begin
                    r_mem[i][w_wr_addr] <= bus.data_in[OUT_WIDTH*i +: DATA_WIDTH];
                end
            end

            // Counter runs during a burst (even with num_cols = 0) and
            // restarts whenever ag_o_on drops.
            if (bus.ag_o_on) begin
                r_wr_cnt <= w_wr_cnt_next;
            end else begin
                r_wr_cnt <= '0;
            end
        end
    end

    assign bus.data_read = r_data_read;

endmodule

// File: tb/tb_o_buffer.sv
module tb_o_buffer;
  localparam int RS = 256;
  localparam int M  = 8;
  localparam int W  = 32;

  logic clk;
  logic reset;

  o_buffer_if #(.RAM_SIZE(RS), .ARRAY_M(M), .OUT_WIDTH(W)) ob_if ();

  o_buffer #(.RAM_SIZE(RS), .ARRAY_M(M), .OUT_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ob_if.slave)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: bank contents plus "has been written" flags
  logic [W-1:0] m_mem [M][RS];
  bit           m_ok  [M][RS];
  int           m_row;

  int n_checks;
  int n_err;

  logic [M*W-1:0] row;

  // One clock cycle: drive inputs, predict, advance, check data_read.
  task automatic step(input logic rst, input logic on, input int nc,
                      input int base, input logic [M*W-1:0] din,
                      input int idx, input int ra, input bit chk,
                      input string tag);
    logic [W-1:0] exp_v;
    bit           known;
    int           addr;
    reset             = rst;
    ob_if.ag_o_on     = on;
    ob_if.num_cols    = 4'(nc);
    ob_if.base_addr   = 8'(base);
    ob_if.data_in     = din;
    ob_if.ram_idx     = 3'(idx);
    ob_if.read_addr   = 8'(ra);
    if (rst) begin
      exp_v = '0;
      known = 1'b1;
      m_row = 0;
    end else begin
      exp_v = m_mem[idx][ra];
      known = m_ok[idx][ra];
      if (on) begin
        addr = (base + m_row) % RS;
        for (int i = 0; i < M; i++) begin
          if (i < nc) begin
            m_mem[i][addr] = din[W*i +: W];
            m_ok[i][addr]  = 1'b1;
          end
        end
        m_row = (m_row + 1) % RS;
      end else begin
        m_row = 0;
      end
    end
    @(posedge clk);
    #1;
    if (chk && known) begin
      n_checks++;
      assert (ob_if.data_read === exp_v) else begin
        n_err++;
        $error("FAIL %s: data_read=%0h expected=%0h (bank %0d addr %0d)",
               tag, ob_if.data_read, exp_v, idx, ra);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 0, '0, 0, 0, 1'b0, "idle");
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    m_row    = 0;
    for (int b = 0; b < M; b++)
      for (int a = 0; a < RS; a++) begin
        m_mem[b][a] = '0;
        m_ok[b][a]  = 1'b0;
      end
    reset = 1'b1;
    ob_if.ag_o_on = 1'b0; ob_if.num_cols = '0; ob_if.base_addr = '0;
    ob_if.data_in = '0; ob_if.ram_idx = '0; ob_if.read_addr = '0;

    // reset state
    step(1'b1, 1'b0, 0, 0, '0, 0, 0, 1'b1, "reset_q");
    step(1'b1, 1'b0, 0, 0, '0, 0, 0, 1'b1, "reset_q2");

    // reset suppresses writes: preload, then attempt a write under reset
    row = '0; row[W-1:0] = 32'h1234;
    step(1'b0, 1'b1, 1, 200, row, 0, 0, 1'b0, "pre");
    idle();
    row[W-1:0] = 32'hDEAD;
    step(1'b1, 1'b1, 8, 200, row, 0, 200, 1'b1, "reset_rd_zero");
    step(1'b0, 1'b0, 0, 0, '0, 0, 200, 1'b1, "reset_no_write");

    // full burst
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < M; i++) row[W*i +: W] = 32'(8*j + i);
      step(1'b0, 1'b1, 8, 16, row, 0, 0, 1'b0, "burst_wr");
    end
    idle();
    for (int i = 0; i < M; i++)
      for (int a = 16; a < 24; a++)
        step(1'b0, 1'b0, 0, 0, '0, i, a, 1'b1, "full_burst");

    // partial columns
    for (int i = 0; i < M; i++) row[W*i +: W] = 32'hAAAA;
    step(1'b0, 1'b1, 8, 40, row, 0, 0, 1'b0, "preload40");
    idle();
    for (int i = 0; i < M; i++) row[W*i +: W] = 32'(i + 1);
    step(1'b0, 1'b1, 3, 40, row, 0, 0, 1'b0, "partial_wr");
    idle();
    for (int i = 0; i < M; i++)
      step(1'b0, 1'b0, 0, 0, '0, i, 40, 1'b1, "partial_cols");

    // burst restart: preload 7,8 then two bursts at base 5
    for (int j = 0; j < 2; j++) begin
      row = '0; row[W-1:0] = 32'(16'h0777 + j);
      step(1'b0, 1'b1, 1, 7, row, 0, 0, 1'b0, "pre78");
    end
    idle();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 2; j++) begin
        row = '0; row[W-1:0] = 32'(16'h0500 + 16'h0100*k + j);
        step(1'b0, 1'b1, 1, 5, row, 0, 0, 1'b0, "restart_wr");
      end
      idle();
    end
    for (int a = 5; a < 9; a++)
      step(1'b0, 1'b0, 0, 0, '0, 0, a, 1'b1, "restart");

    // address wrap
    for (int j = 0; j < 4; j++) begin
      row = '0; row[W-1:0] = 32'(100 + j);
      step(1'b0, 1'b1, 1, 254, row, 0, 0, 1'b0, "wrap_wr");
    end
    idle();
    step(1'b0, 1'b0, 0, 0, '0, 0, 254, 1'b1, "wrap");
    step(1'b0, 1'b0, 0, 0, '0, 0, 255, 1'b1, "wrap");
    step(1'b0, 1'b0, 0, 0, '0, 0, 0, 1'b1, "wrap");
    step(1'b0, 1'b0, 0, 0, '0, 0, 1, 1'b1, "wrap");

    // num_cols = 0 still advances the counter; num_cols > ARRAY_M clamps
    for (int i = 0; i < M; i++) row[W*i +: W] = 32'h6000 + 32'(i);
    step(1'b0, 1'b1, 8, 60, row, 0, 0, 1'b0, "pre60");
    idle();
    for (int i = 0; i < M; i++) row[W*i +: W] = 32'h7000 + 32'(i);
    step(1'b0, 1'b1, 0, 60, row, 0, 0, 1'b0, "nc0_wr");
    for (int i = 0; i < M; i++) row[W*i +: W] = 32'h8000 + 32'(i);
    step(1'b0, 1'b1, 15, 60, row, 0, 0, 1'b0, "nc15_wr");
    idle();
    for (int i = 0; i < M; i++) begin
      step(1'b0, 1'b0, 0, 0, '0, i, 60, 1'b1, "ncols0");
      step(1'b0, 1'b0, 0, 0, '0, i, 61, 1'b1, "ncols_clamp");
    end

    // read during write: old value, then new value
    for (int i = 0; i < M; i++) row[W*i +: W] = 32'hC0DE0000 + 32'(i);
    step(1'b0, 1'b1, 8, 16, row, 0, 16, 1'b1, "rdw_old");
    step(1'b0, 1'b0, 0, 0, '0, 0, 16, 1'b1, "rdw_new");

    // randomized traffic, including occasional reset and mid-burst changes
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < M; i++) row[W*i +: W] = $urandom;
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0),
           int'($urandom_range(0, 15)),
           ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, RS-1)) : 250,
           row, int'($urandom_range(0, M-1)), int'($urandom_range(0, RS-1)),
           1'b1, "random");
    end
    for (int i = 0; i < M; i++)
      for (int a = 246; a < 256; a++)
        step(1'b0, 1'b0, 0, 0, '0, i, a, 1'b1, "random_sweep");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
